kernel_buffer_pingpong: RTL and testbench
=========================================

# kernel_buffer_pingpong

Double-buffered KxK convolution weight store between the AXI4-Stream weight loader and the Conv2D MAC array. Packs WIDTH-bit stream beats into LANES-wide words, fills one bank while the MAC array reads the other, and promotes banks without a read-side gap. Kernel size, lane count and depth are parameters. A tlast framing check reports malformed weight sets.

## Interface
- WIDTH, 16, bits per weight element
- LANES, 4, elements per buffer word; word width is LANES*WIDTH
- DEPTH, 512, words per tap per bank (kernels × channels / LANES)
- KSIZE, 3, kernel edge; TAPS = KSIZE*KSIZE; SET = TAPS*DEPTH words, SET*LANES beats
- i_aclk  in  1  clock
- i_aresetn  in  1  reset; asynchronous and active-low
- i_tvalid  in  1  stream beat valid
- o_tready  out  1  stream ready
- i_tdata  in  WIDTH  weight element
- i_tlast  in  1  marks final beat of a weight set
- i_sel  in  clog2(DEPTH)  read address, same for all taps
- i_rd_en  in  1  capture read data this cycle
- i_release  in  1  single-cycle pulse; consumer finished with active bank
- o_buf_valid  out  1  active bank holds a complete set
- o_bank  out  1  index of active bank
- o_buf  out  TAPS*LANES*WIDTH  all taps at i_sel; tap t occupies bits [(t+1)*LANES*WIDTH-1 : t*LANES*WIDTH], t = row*KSIZE+col
- o_err  out  1  sticky tlast framing error

## Operation
- Packing: first beat of a word → lane 0 (LSBs), LANES-th beat → lane LANES-1; word written on the LANES-th accepted beat.
- Fill order: tap 0 addresses 0..DEPTH-1, then tap 1, …, tap TAPS-1. Word counter 0..SET-1, wraps to 0 at set end.
- Bank state: wb (write bank), act_v (active valid), pend (write bank full, awaiting promotion). Active bank = ~wb whenever act_v=1.
- o_tready = aresetn-released && !pend.
- Final beat of a set accepted:
  - act_v=0 → active ← wb, wb ← ~wb, act_v ← 1.
  - act_v=1, no release same cycle → pend ← 1.
  - act_v=1 with i_release same cycle → promote as for act_v=0; act_v stays 1.
- i_release with act_v=1: pend=1 → promote pending bank, wb ← old active, pend ← 0, act_v stays 1; pend=0 → act_v ← 0, bank freed.
- i_release with act_v=0: ignored.
- Read: on i_rd_en, o_buf ← active bank[i_sel] for all taps; otherwise o_buf holds. Read with act_v=0 loads zeros.
- Framing: i_tlast on any beat other than beat SET*LANES-1, or absent on that beat, sets o_err. Framing is beat-count based; o_err does not alter fill. Cleared only by reset.

## Timing
- Reset (async assert, sync-released): o_tready 0, o_buf_valid 0, o_bank 0, o_buf 0, o_err 0; wb=0, counters 0, pend=0. o_tready rises first clock after release. Reset mid-fill discards partial set and both banks.
- Read latency 1 cycle: i_sel/i_rd_en at edge N → o_buf valid after edge N+1.
- Promotion registered: o_buf_valid/o_bank update the cycle after the triggering beat or release; a read sampled on that same edge uses the pre-promotion active bank.
- o_tready falls the cycle after the final beat when pend sets; rises the cycle after the releasing pulse.
- o_err asserts the cycle after the offending beat.
- Sustained throughput: 1 beat/cycle while !pend.

## Test plan
Parameters WIDTH=8, LANES=2, DEPTH=4, KSIZE=3 (SET=36 words, 72 beats).
- Reset then 72 beats data=beat index, tlast on beat 71 -> o_buf_valid=1 next cycle, o_bank=0; read i_sel=1 gives tap 0 word {8'h03,8'h02}, tap 8 word {8'h43,8'h42}; o_err=0.
- Second set (data+0x80) while set 1 active -> o_tready drops after beat 71; i_release -> o_bank=1 next cycle, o_buf_valid never drops, o_tready high; i_sel=0 tap 0 = {8'h81,8'h80}.
- Final beat and i_release same cycle with act_v=1 -> immediate promotion, o_buf_valid continuous, pend stays 0.
- i_release with no pending set -> o_buf_valid=0 next cycle; reads return 0; i_release while invalid ignored.
- tlast on beat 35 -> o_err=1 next cycle, stays set; set still completes at beat 71.
- Reset asserted at beat 40 of second set with bank 0 active -> all outputs at reset values immediately; fresh 72-beat set lands in bank 0.

Source files
------------

// File: rtl/kernel_buffer_pingpong_if.sv
// rtl/kernel_buffer_pingpong_if.sv - weight stream handshake bundle between loader and buffer
interface kernel_buffer_pingpong_if #(
  parameter int WIDTH = 16
) ();
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;
  logic             tlast;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/kernel_buffer_pingpong.sv
// rtl/kernel_buffer_pingpong.sv - double-buffered KxK weight store with lane packing and tlast framing check
module kernel_buffer_pingpong #(
  parameter int WIDTH = 16,
  parameter int LANES = 4,
  parameter int DEPTH = 512,
  parameter int KSIZE = 3,
  localparam int TAPS   = KSIZE * KSIZE,
  localparam int WORD_W = LANES * WIDTH,
  localparam int SEL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     i_aclk,
  input  logic                     i_aresetn,
  kernel_buffer_pingpong_if.slave  s_axis,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic                     i_rd_en,
  input  logic                     i_release,
  output logic                     o_buf_valid,
  output logic                     o_bank,
  output logic [TAPS*WORD_W-1:0]   o_buf,
  output logic                     o_err
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;

  // Ready is held low for the first clock after reset release so the
  // loader never sees a beat accepted while the counters are settling.
  logic                    rst_done_q, rst_done_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [SEL_W-1:0]        addr_q, addr_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic [WORD_W-1:0]       pack_q, pack_d;
  logic                    wb_q, wb_d;
  logic                    act_v_q, act_v_d;
  logic                    pend_q, pend_d;
  logic                    err_q, err_d;
  logic [TAPS*WORD_W-1:0]  buf_q, buf_d;

  logic tready;
  logic fire;
  logic lane_last, addr_last, tap_last, set_last;
  logic last_beat;
  logic rel;
  logic wr_en;

  // Storage is indexed [bank][tap][addr] so every tap can be read at the
  // same address in one cycle; contents are not reset because a reset
  // already invalidates both banks through act_v.
  logic [WORD_W-1:0] mem_q [2][TAPS][DEPTH];

  assign tready        = rst_done_q && !pend_q;
  assign s_axis.tready = tready;
  assign o_buf_valid   = act_v_q;
  assign o_bank        = act_v_q & ~wb_q;
  assign o_buf         = buf_q;
  assign o_err         = err_q;

  // Beat acceptance and position of the current beat within the weight set.
  always_comb begin
    fire      = s_axis.tvalid && tready;
    lane_last = (lane_q == LANE_W'(LANES - 1));
    addr_last = (addr_q == SEL_W'(DEPTH - 1));
    tap_last  = (tap_q == TAP_W'(TAPS - 1));
    set_last  = lane_last && addr_last && tap_last;
    last_beat = fire && set_last;
    rel       = i_release && act_v_q;
  end

  // Lane packing and fill-order counters; a word is committed on its last lane.
  always_comb begin
    lane_d = lane_q;
    addr_d = addr_q;
    tap_d  = tap_q;
    pack_d = pack_q;
    wr_en  = 1'b0;
    if (fire) begin
      pack_d[lane_q*WIDTH +: WIDTH] = s_axis.tdata;
      if (lane_last) begin
        lane_d = '0;
        wr_en  = 1'b1;
        if (addr_last) begin
          addr_d = '0;
          tap_d  = tap_last ? '0 : tap_q + 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  // Bank promotion, release handling and sticky framing error.
  always_comb begin
    rst_done_d = 1'b1;
    wb_d       = wb_q;
    act_v_d    = act_v_q;
    pend_d     = pend_q;
    err_d      = err_q;
    if (last_beat) begin
      if (!act_v_q) begin
        wb_d    = ~wb_q;
        act_v_d = 1'b1;
      end else if (rel) begin
        // Consumer lets go of the old set on the same edge the new one
        // completes: swap directly so the read side never sees a gap.
        wb_d = ~wb_q;
      end else begin
        pend_d = 1'b1;
      end
    end else if (rel) begin
      if (pend_q) begin
        wb_d   = ~wb_q;
        pend_d = 1'b0;
      end else begin
        act_v_d = 1'b0;
      end
    end
    // Framing is judged purely on beat count; the fill itself carries on.
    if (fire && (s_axis.tlast != set_last)) begin
      err_d = 1'b1;
    end
  end

  // Read capture: all taps of the active bank at i_sel, zeros when no set is active.
  always_comb begin
    buf_d = buf_q;
    if (i_rd_en) begin
      for (int t = 0; t < TAPS; t++) begin
        buf_d[t*WORD_W +: WORD_W] = act_v_q ? mem_q[~wb_q][TAP_W'(t)][i_sel] : '0;
      end
    end
  end

  // Control and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      rst_done_q <= 1'b0;
      lane_q     <= '0;
      addr_q     <= '0;
      tap_q      <= '0;
      pack_q     <= '0;
      wb_q       <= 1'b0;
      act_v_q    <= 1'b0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      buf_q      <= '0;
    end else begin
      rst_done_q <= rst_done_d;
      lane_q     <= lane_d;
      addr_q     <= addr_d;
      tap_q      <= tap_d;
      pack_q     <= pack_d;
      wb_q       <= wb_d;
      act_v_q    <= act_v_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      buf_q      <= buf_d;
    end
  end

  // Word write into the fill bank.
  always_ff @(posedge i_aclk) begin
    if (wr_en) begin
      mem_q[wb_q][tap_q][addr_q] <= pack_d;
    end
  end

endmodule

// File: tb/tb_kernel_buffer_pingpong.sv
// tb/tb_kernel_buffer_pingpong.sv - directed self-checking bench for kernel_buffer_pingpong
module tb_kernel_buffer_pingpong;
  localparam int WIDTH = 8;
  localparam int LANES = 2;
  localparam int DEPTH = 4;
  localparam int KSIZE = 3;
  localparam int BUF_W = KSIZE * KSIZE * LANES * WIDTH;

  logic             clk;
  logic             rst_n;
  logic [1:0]       i_sel;
  logic             i_rd_en;
  logic             i_release;
  logic             o_buf_valid;
  logic             o_bank;
  logic [BUF_W-1:0] o_buf;
  logic             o_err;

  int tests_run;
  int tests_failed;

  kernel_buffer_pingpong_if #(.WIDTH(WIDTH)) axis ();

  kernel_buffer_pingpong #(
    .WIDTH(WIDTH),
    .LANES(LANES),
    .DEPTH(DEPTH),
    .KSIZE(KSIZE)
  ) dut (
    .i_aclk      (clk),
    .i_aresetn   (rst_n),
    .s_axis      (axis),
    .i_sel       (i_sel),
    .i_rd_en     (i_rd_en),
    .i_release   (i_release),
    .o_buf_valid (o_buf_valid),
    .o_bank      (o_bank),
    .o_buf       (o_buf),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BUF_W-1:0] got, input logic [BUF_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected o_buf for a set whose beat k carried (k + off), read at address a.
  function automatic logic [BUF_W-1:0] exp_buf(input logic [7:0] off, input int a);
    logic [BUF_W-1:0] r;
    logic [7:0] lo, hi;
    int w;
    r = '0;
    for (int t = 0; t < KSIZE * KSIZE; t++) begin
      w  = t * DEPTH + a;
      lo = 8'(2 * w) + off;
      hi = 8'(2 * w + 1) + off;
      r[t*16 +: 16] = {hi, lo};
    end
    return r;
  endfunction

  task automatic send_set(input logic [7:0] off, input int n, input int extra_last, input logic rel_on_last);
    int guard;
    for (int i = 0; i < n; i++) begin
      guard       = 0;
      axis.tvalid = 1'b1;
      axis.tdata  = 8'(i) + off;
      axis.tlast  = (i == 71) || (i == extra_last);
      i_release   = rel_on_last && (i == 71);
      while (!axis.tready && guard < 200) begin
        cycle();
        guard++;
      end
      if (guard >= 200) check("tready_wait", axis.tready, 1'b1);
      cycle();
      i_release = 1'b0;
      if (i == extra_last - 1) check("err_before_bad", o_err, 1'b0);
      if (i == extra_last) check("err_after_bad", o_err, 1'b1);
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
  endtask

  task automatic read_sel(input logic [1:0] s);
    i_sel   = s;
    i_rd_en = 1'b1;
    cycle();
    i_rd_en = 1'b0;
  endtask

  task automatic pulse_release();
    i_release = 1'b1;
    cycle();
    i_release = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    axis.tvalid  = 1'b0;
    axis.tdata   = '0;
    axis.tlast   = 1'b0;
    i_sel        = '0;
    i_rd_en      = 1'b0;
    i_release    = 1'b0;

    repeat (3) cycle();
    check("rst_tready", axis.tready, 1'b0);
    check("rst_valid", o_buf_valid, 1'b0);
    check("rst_bank", o_bank, 1'b0);
    check("rst_buf", o_buf, '0);
    check("rst_err", o_err, 1'b0);
    rst_n = 1'b1;
    #1;
    check("tready_at_release", axis.tready, 1'b0);
    cycle();
    check("tready_after_release", axis.tready, 1'b1);

    // Set 1: data = beat index, lands in bank 0.
    send_set(8'h00, 72, -1, 1'b0);
    check("s1_valid", o_buf_valid, 1'b1);
    check("s1_bank", o_bank, 1'b0);
    check("s1_err", o_err, 1'b0);
    check("s1_tready", axis.tready, 1'b1);
    read_sel(2'd1);
    check("s1_tap0", o_buf[15:0], 16'h0302);
    check("s1_tap8", o_buf[143:128], 16'h4342);
    check("s1_buf", o_buf, exp_buf(8'h00, 1));

    // Set 2 while set 1 active: pends until release.
    send_set(8'h80, 72, -1, 1'b0);
    check("s2_tready_pend", axis.tready, 1'b0);
    check("s2_valid_pend", o_buf_valid, 1'b1);
    check("s2_bank_pend", o_bank, 1'b0);
    read_sel(2'd0);
    check("s2_read_old", o_buf, exp_buf(8'h00, 0));
    pulse_release();
    check("s2_bank", o_bank, 1'b1);
    check("s2_valid", o_buf_valid, 1'b1);
    check("s2_tready", axis.tready, 1'b1);
    read_sel(2'd0);
    check("s2_tap0", o_buf[15:0], 16'h8180);
    check("s2_buf", o_buf, exp_buf(8'h80, 0));

    // Set 3: final beat with simultaneous release swaps immediately.
    send_set(8'h20, 72, -1, 1'b1);
    check("s3_valid", o_buf_valid, 1'b1);
    check("s3_bank", o_bank, 1'b0);
    check("s3_tready", axis.tready, 1'b1);
    read_sel(2'd2);
    check("s3_buf", o_buf, exp_buf(8'h20, 2));

    // Release without a pending set frees the bank; a second release is ignored.
    pulse_release();
    check("free_valid", o_buf_valid, 1'b0);
    read_sel(2'd3);
    check("free_read_zero", o_buf, '0);
    pulse_release();
    check("ignored_valid", o_buf_valid, 1'b0);
    check("ignored_tready", axis.tready, 1'b1);

    // Set 4: premature tlast on beat 35.
    send_set(8'h10, 72, 35, 1'b0);
    check("s4_valid", o_buf_valid, 1'b1);
    check("s4_bank", o_bank, 1'b1);
    check("s4_err_sticky", o_err, 1'b1);
    read_sel(2'd1);
    check("s4_buf", o_buf, exp_buf(8'h10, 1));

    // Free bank 1, fill bank 0 so it is the active bank for the reset case.
    pulse_release();
    send_set(8'h30, 72, -1, 1'b0);
    check("s5_bank", o_bank, 1'b0);
    read_sel(2'd0);
    check("s5_buf", o_buf, exp_buf(8'h30, 0));

    // Reset in the middle of the next set.
    send_set(8'h60, 40, -1, 1'b0);
    axis.tvalid = 1'b1;
    axis.tdata  = 8'h88;
    rst_n       = 1'b0;
    #1;
    check("mid_rst_tready", axis.tready, 1'b0);
    check("mid_rst_valid", o_buf_valid, 1'b0);
    check("mid_rst_bank", o_bank, 1'b0);
    check("mid_rst_buf", o_buf, '0);
    check("mid_rst_err", o_err, 1'b0);
    axis.tvalid = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();

    send_set(8'h50, 72, -1, 1'b0);
    check("s7_valid", o_buf_valid, 1'b1);
    check("s7_bank", o_bank, 1'b0);
    check("s7_err", o_err, 1'b0);
    read_sel(2'd3);
    check("s7_tap8", o_buf[143:128], 16'h9796);
    check("s7_buf", o_buf, exp_buf(8'h50, 3));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
